// File: rtl/csr_write_sequencer.sv
// Serialises up to three CSR writes and one privilege-mode change per retiring instruction onto one write port.
// Latency: first strobe one cycle after capture; k writes + p priv keep ok_to_proceed low k+p+1 cycles.
// Backpressure: csr_ready low holds csr_we/csr_waddr/csr_wdata stable; the next slot issues the cycle after acceptance.
module csr_write_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CSR_wbEn,
    input  logic [ADDR_W-1:0] CSR_addr,
    input  logic [DATA_W-1:0] CSR_value,
    input  logic              CSR_wbEn2,
    input  logic [ADDR_W-1:0] CSR_addr2,
    input  logic [DATA_W-1:0] CSR_value2,
    input  logic              CSR_wbEn3,
    input  logic [ADDR_W-1:0] CSR_addr3,
    input  logic [DATA_W-1:0] CSR_value3,
    input  logic              priviledgeModeWrite,
    input  logic [MODE_W-1:0] newPriviledgeMode,
    input  logic              ok_to_proceed_overall,
    input  logic              csr_ready,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0] csr_wdata,
    output logic              priv_we,
    output logic [MODE_W-1:0] priv_mode,
    output logic              ok_to_proceed
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] PRIV  = 2'd2;

    logic [1:0]        state;
    logic              armed;
    logic [2:0]        mask;
    logic              priv_pend;
    logic [MODE_W-1:0] mode_q;
    logic [ADDR_W-1:0] addr_q [3];
    logic [DATA_W-1:0] data_q [3];
    logic [ADDR_W-1:0] addr_in [3];
    logic [DATA_W-1:0] data_in [3];
    logic [2:0]        en_in;
    logic [2:0]        mask_rem;
    logic [1:0]        first_idx;
    logic [1:0]        next_idx;
    logic              any_req;
    logic              capture;

    function automatic logic [1:0] low_idx(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    assign en_in      = {CSR_wbEn3, CSR_wbEn2, CSR_wbEn};
    assign any_req    = (|en_in) | priviledgeModeWrite;
    assign capture    = (state == IDLE) & armed & any_req;
    assign ok_to_proceed = (state == IDLE) & ~(armed & any_req);

    assign addr_in[0] = CSR_addr;
    assign addr_in[1] = CSR_addr2;
    assign addr_in[2] = CSR_addr3;
    assign data_in[0] = CSR_value;
    assign data_in[1] = CSR_value2;
    assign data_in[2] = CSR_value3;

    // mask still holds the slot on the bus; strip its lowest bit to find what follows
    assign mask_rem  = mask & ~(mask & (~mask + 3'd1));
    assign first_idx = low_idx(en_in);
    assign next_idx  = low_idx(mask_rem);

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 3; i++) begin
                addr_q[i] <= addr_in[i];
                data_q[i] <= data_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b1;
            mask      <= 3'b000;
            priv_pend <= 1'b0;
            mode_q    <= '0;
            csr_we    <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
            priv_we   <= 1'b0;
            priv_mode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed && any_req) begin
                        armed     <= 1'b0;
                        mask      <= en_in;
                        priv_pend <= priviledgeModeWrite;
                        mode_q    <= newPriviledgeMode;
                        if (|en_in) begin
                            state     <= WRITE;
                            csr_we    <= 1'b1;
                            csr_waddr <= addr_in[first_idx];
                            csr_wdata <= data_in[first_idx];
                        end else begin
                            state     <= PRIV;
                            priv_we   <= 1'b1;
                            priv_mode <= newPriviledgeMode;
                        end
                    end else if (ok_to_proceed_overall) begin
                        armed <= 1'b1;
                    end
                end
                WRITE: begin
                    if (csr_ready) begin
                        mask <= mask_rem;
                        if (|mask_rem) begin
                            csr_waddr <= addr_q[next_idx];
                            csr_wdata <= data_q[next_idx];
                        end else begin
                            csr_we <= 1'b0;
                            if (priv_pend) begin
                                state     <= PRIV;
                                priv_we   <= 1'b1;
                                priv_mode <= mode_q;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                PRIV: begin
                    priv_we   <= 1'b0;
                    priv_pend <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_write_sequencer.sv
// Bench for csr_write_sequencer: directed scenarios with literal expectations plus randomized traffic against a queue-based model.
module tb_csr_write_sequencer;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          CSR_wbEn, CSR_wbEn2, CSR_wbEn3;
    logic [AW-1:0] CSR_addr, CSR_addr2, CSR_addr3;
    logic [DW-1:0] CSR_value, CSR_value2, CSR_value3;
    logic          priviledgeModeWrite;
    logic [MW-1:0] newPriviledgeMode;
    logic          ok_to_proceed_overall;
    logic          csr_ready;
    logic          csr_we;
    logic [AW-1:0] csr_waddr;
    logic [DW-1:0] csr_wdata;
    logic          priv_we;
    logic [MW-1:0] priv_mode;
    logic          ok_to_proceed;

    csr_write_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MODE_W(MW)) dut (
        .clk(clk), .rst(rst),
        .CSR_wbEn(CSR_wbEn), .CSR_addr(CSR_addr), .CSR_value(CSR_value),
        .CSR_wbEn2(CSR_wbEn2), .CSR_addr2(CSR_addr2), .CSR_value2(CSR_value2),
        .CSR_wbEn3(CSR_wbEn3), .CSR_addr3(CSR_addr3), .CSR_value3(CSR_value3),
        .priviledgeModeWrite(priviledgeModeWrite), .newPriviledgeMode(newPriviledgeMode),
        .ok_to_proceed_overall(ok_to_proceed_overall), .csr_ready(csr_ready),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .priv_we(priv_we), .priv_mode(priv_mode), .ok_to_proceed(ok_to_proceed)
    );

    always #5 clk = ~clk;

    // Model: a list of outstanding actions for the captured instruction, head is what the bus shows
    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mode;
    } act_t;

    act_t          mq[$];
    logic          m_armed;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_mode;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  running = 1'b1;
    int  cyc = 0;

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            log_cyc[$];
    int            we_cycles, priv_cnt, priv_cyc, ok_low;
    logic [MW-1:0] priv_log_mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_armed = 1'b1;
        m_waddr = '0;
        m_wdata = '0;
        m_mode  = '0;
    endtask

    function automatic logic any_req();
        return CSR_wbEn | CSR_wbEn2 | CSR_wbEn3 | priviledgeModeWrite;
    endfunction

    // Per-cycle compare against the model, plus a log used by the directed scenarios
    initial begin
        act_t a;
        bit   busy;
        m_reset();
        while (running) begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                m_reset();
                chk("rst_csr_we", csr_we, 0);
                chk("rst_priv_we", priv_we, 0);
                chk("rst_waddr", csr_waddr, 0);
                chk("rst_wdata", csr_wdata, 0);
                chk("rst_priv_mode", priv_mode, 0);
                chk("rst_ok", ok_to_proceed, !any_req());
            end else begin
                busy = (mq.size() > 0);
                if (busy) begin
                    if (mq[0].is_wr) begin
                        m_waddr = mq[0].addr;
                        m_wdata = mq[0].data;
                    end else begin
                        m_mode = mq[0].mode;
                    end
                end
                chk("csr_we", csr_we, busy && mq[0].is_wr);
                chk("priv_we", priv_we, busy && !mq[0].is_wr);
                chk("csr_waddr", csr_waddr, m_waddr);
                chk("csr_wdata", csr_wdata, m_wdata);
                chk("priv_mode", priv_mode, m_mode);
                chk("ok_to_proceed", ok_to_proceed, !busy && !(m_armed && any_req()));
                if (busy) begin
                    if (!mq[0].is_wr || csr_ready) void'(mq.pop_front());
                end else if (m_armed && any_req()) begin
                    m_armed = 1'b0;
                    a.mode = newPriviledgeMode;
                    a.is_wr = 1'b1;
                    if (CSR_wbEn)  begin a.addr = CSR_addr;  a.data = CSR_value;  mq.push_back(a); end
                    if (CSR_wbEn2) begin a.addr = CSR_addr2; a.data = CSR_value2; mq.push_back(a); end
                    if (CSR_wbEn3) begin a.addr = CSR_addr3; a.data = CSR_value3; mq.push_back(a); end
                    if (priviledgeModeWrite) begin a.is_wr = 1'b0; mq.push_back(a); end
                end else if (ok_to_proceed_overall) begin
                    m_armed = 1'b1;
                end
            end
            if (csr_we) we_cycles++;
            if (csr_we && csr_ready) begin
                log_addr.push_back(csr_waddr);
                log_data.push_back(csr_wdata);
                log_cyc.push_back(cyc);
            end
            if (priv_we) begin
                priv_cnt++;
                priv_cyc = cyc;
                priv_log_mode = priv_mode;
            end
            if (!ok_to_proceed) ok_low++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_reqs();
        CSR_wbEn = 0; CSR_wbEn2 = 0; CSR_wbEn3 = 0;
        priviledgeModeWrite = 0;
        ok_to_proceed_overall = 0;
    endtask

    task automatic clr_log();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        we_cycles = 0; priv_cnt = 0; priv_cyc = 0; ok_low = 0; priv_log_mode = '0;
    endtask

    task automatic rearm();
        ok_to_proceed_overall = 1;
        step(1);
        ok_to_proceed_overall = 0;
        step(1);
    endtask

    task automatic set_slots(input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                             input logic e2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                             input logic e3, input logic [AW-1:0] a3, input logic [DW-1:0] d3);
        CSR_wbEn = e1;  CSR_addr = a1;  CSR_value = d1;
        CSR_wbEn2 = e2; CSR_addr2 = a2; CSR_value2 = d2;
        CSR_wbEn3 = e3; CSR_addr3 = a3; CSR_value3 = d3;
    endtask

    initial begin
        rst = 1;
        csr_ready = 1;
        newPriviledgeMode = 0;
        clr_reqs();
        set_slots(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr_log();
        step(2);
        rst = 0;
        step(1);
        chk("idle_ok_after_reset", ok_to_proceed, 1);

        // single write
        clr_log();
        set_slots(1, 12'h300, 64'h8, 0, 0, 0, 0, 0, 0);
        step(1);
        clr_reqs();
        step(4);
        chk("t1_nwrites", log_addr.size(), 1);
        chk("t1_addr", log_addr[0], 12'h300);
        chk("t1_data", log_data[0], 64'h8);
        chk("t1_we_cycles", we_cycles, 1);
        chk("t1_ok_low", ok_low, 2);
        rearm();

        // three writes plus privilege change
        clr_log();
        set_slots(1, 12'h341, 64'h1000, 1, 12'h342, 64'hB, 1, 12'h300, 64'h80);
        priviledgeModeWrite = 1;
        newPriviledgeMode = 2'd0;
        step(1);
        clr_reqs();
        step(7);
        chk("t2_nwrites", log_addr.size(), 3);
        chk("t2_addr0", log_addr[0], 12'h341);
        chk("t2_addr1", log_addr[1], 12'h342);
        chk("t2_addr2", log_addr[2], 12'h300);
        chk("t2_gap01", log_cyc[1] - log_cyc[0], 1);
        chk("t2_gap12", log_cyc[2] - log_cyc[1], 1);
        chk("t2_priv_cnt", priv_cnt, 1);
        chk("t2_priv_after", priv_cyc - log_cyc[2], 1);
        chk("t2_priv_mode", priv_log_mode, 0);
        chk("t2_ok_low", ok_low, 5);
        rearm();

        // backpressure on the first write, slot 2 disabled
        clr_log();
        csr_ready = 0;
        set_slots(1, 12'h341, 64'h1000, 0, 12'h342, 64'hB, 1, 12'h300, 64'h80);
        step(1);
        clr_reqs();
        step(3);
        csr_ready = 1;
        step(4);
        chk("t3_nwrites", log_addr.size(), 2);
        chk("t3_addr0", log_addr[0], 12'h341);
        chk("t3_addr1", log_addr[1], 12'h300);
        chk("t3_we_cycles", we_cycles, 5);
        rearm();

        // held request captured once per step
        clr_log();
        set_slots(1, 12'h340, 64'h55, 0, 0, 0, 0, 0, 0);
        step(6);
        clr_reqs();
        step(2);
        chk("t4_held_once", log_addr.size(), 1);
        rearm();
        set_slots(1, 12'h340, 64'h66, 0, 0, 0, 0, 0, 0);
        step(1);
        clr_reqs();
        step(3);
        chk("t4_second", log_addr.size(), 2);
        chk("t4_second_data", log_data[1], 64'h66);
        rearm();

        // duplicate address: both issue, higher slot last
        clr_log();
        set_slots(1, 12'h305, 64'h10, 1, 12'h305, 64'h20, 0, 0, 0);
        step(1);
        clr_reqs();
        step(4);
        chk("t5_nwrites", log_addr.size(), 2);
        chk("t5_data0", log_data[0], 64'h10);
        chk("t5_data1", log_data[1], 64'h20);
        chk("t5_addr1", log_addr[1], 12'h305);
        rearm();

        // reset during the second of three writes
        clr_log();
        set_slots(1, 12'h341, 64'h1000, 1, 12'h342, 64'hB, 1, 12'h300, 64'h80);
        step(1);
        clr_reqs();
        step(1);
        rst = 1;
        #1;
        chk("t6_csr_we", csr_we, 0);
        chk("t6_waddr", csr_waddr, 0);
        chk("t6_wdata", csr_wdata, 0);
        chk("t6_priv_we", priv_we, 0);
        chk("t6_priv_mode", priv_mode, 0);
        chk("t6_ok", ok_to_proceed, 1);
        step(1);
        rst = 0;
        step(5);
        chk("t6_nwrites", log_addr.size(), 1);
        chk("t6_addr0", log_addr[0], 12'h341);

        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            CSR_wbEn  = ($urandom_range(0, 2) == 0);
            CSR_wbEn2 = ($urandom_range(0, 2) == 0);
            CSR_wbEn3 = ($urandom_range(0, 2) == 0);
            priviledgeModeWrite = ($urandom_range(0, 3) == 0);
            CSR_addr  = AW'($urandom);
            CSR_addr2 = AW'($urandom);
            CSR_addr3 = AW'($urandom);
            CSR_value  = {$urandom, $urandom};
            CSR_value2 = {$urandom, $urandom};
            CSR_value3 = {$urandom, $urandom};
            newPriviledgeMode = MW'($urandom);
            csr_ready = ($urandom_range(0, 9) < 7);
            ok_to_proceed_overall = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 0;
        clr_reqs();
        csr_ready = 1;
        step(8);

        running = 0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
